rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port req0, input, 1: requester 0 read request, held high until gnt0.
REQ-004 SHALL have port addr0, input, 4: requester 0 start word address, sampled with gnt0.
REQ-005 SHALL have port len0, input, 2: requester 0 burst length minus one (1-4 words), sampled with gnt0.
REQ-006 SHALL have ports req1, addr1 and len1, with widths 1, 4 and 2, identical in meaning for requester 1.
REQ-007 SHALL have ports gnt0 and gnt1, outputs, 1 each: one-cycle grant pulses.
REQ-008 SHALL have ports rvalid0 and rvalid1, outputs, 1 each: rdata holds a word for that requester.
REQ-009 SHALL have port rdata, output, 16: read data, equal to rom_data.
REQ-010 SHALL have port rom_addr, output, 4: registered address to the shared ROM.
REQ-011 SHALL have port rom_data, input, 16: ROM word, valid the cycle after rom_addr is sampled.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, BURST and DRAIN.
REQ-014 IDLE, with at least one req high: SHALL pulse exactly one gnt, capture that requester's addr and len into cur_addr and beats_left, and move to BURST next cycle.
REQ-015 Arbitration with both reqs high SHALL be round-robin: the requester not granted last wins; priority pointer resets to requester 0.
REQ-016 Priority pointer SHALL update only on a grant, to favour the other requester.
REQ-017 BURST SHALL drive rom_addr=cur_addr each cycle, then increment cur_addr modulo 16 (15 wraps to 0) and decrement beats_left.
REQ-018 BURST with beats_left=0 (last word issued) SHALL move to DRAIN; DRAIN SHALL move to IDLE after one cycle.
REQ-019 rvalidN SHALL be high exactly in the cycle after each BURST issue cycle, for the owning requester only; rvalid0 and rvalid1 are never high together.
REQ-020 Latency SHALL be: gnt in cycle t; first issue in t+1; first rvalid in t+2; last rvalid in t+2+len.
REQ-021 A new grant SHALL be possible no earlier than the cycle after DRAIN (back-to-back burst gap = 1 cycle beyond the last rvalid).
REQ-022 req changes during BURST or DRAIN SHALL be ignored; grants are issued from IDLE only.
REQ-023 A req that drops before its grant SHALL receive no grant and no data.
REQ-024 The owner identity SHALL be held registered for the whole burst, independent of the live req, addr and len inputs.
REQ-025 rom_addr SHALL hold its last value outside BURST.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE; gnt0/1=0; rvalid0/1=0; busy=0; rom_addr=0; cur_addr=0; beats_left=0; priority pointer=requester 0.
REQ-027 Reset mid-burst SHALL abort the burst with no further rvalid; the first grant after release follows REQ-014 from IDLE.
REQ-028 rdata SHALL carry no reset requirement; it is meaningful only while an rvalid is high.

Verification
REQ-029 Setup: the bench ROM model SHALL return 16'hA000+address one cycle after address. Case: req0, addr0=3, len0=0 -> gnt0 in t, rvalid0 only in t+2, rdata=16'hA003, busy low at t+4.
REQ-030 req1, addr1=14, len1=3 -> rvalid1 in t+2..t+5 with rdata A00E, A00F, A000, A001 (wrap).
REQ-031 req0 and req1 high together from reset, len=1 each, held -> gnt0 first; gnt1 one cycle after DRAIN; then gnt0 again (alternation).
REQ-032 req1 asserted mid-burst of requester 0 -> no gnt1 until IDLE; rvalid1 never overlaps rvalid0.
REQ-033 rst_n pulsed low during the second beat of a 4-word burst -> rvalid and busy fall immediately; no later beats; next req0 gets a normal grant.
REQ-034 req0 pulsed for one cycle while requester 1 owns the bus, dropped before IDLE -> no gnt0, no rvalid0.

Source files
------------

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-requester round-robin burst reader for a shared single-port ROM
// Grants come from IDLE only; the owner, address and beat count are held until the burst drains.
module rom_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [3:0]  addr0,
   input  logic [1:0]  len0,
   input  logic        req1,
   input  logic [3:0]  addr1,
   input  logic [1:0]  len1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata,
   output logic [3:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t     state, state_nxt;
   logic [3:0] cur_addr, cur_addr_nxt;
   logic [3:0] rom_addr_nxt;
   logic [1:0] beats_left, beats_nxt;
   logic       owner, owner_nxt;
   logic       prio, prio_nxt;
   logic       gnt0_c, gnt1_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_addr   <= 4'd0;
         rom_addr   <= 4'd0;
         beats_left <= 2'd0;
         owner      <= 1'b0;
         prio       <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur_addr   <= cur_addr_nxt;
         rom_addr   <= rom_addr_nxt;
         beats_left <= beats_nxt;
         owner      <= owner_nxt;
         prio       <= prio_nxt;
         // ROM answers one cycle after an issue, so valid trails the BURST cycle
         rvalid0    <= (state == BURST) && !owner;
         rvalid1    <= (state == BURST) && owner;
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_addr_nxt = cur_addr;
      rom_addr_nxt = rom_addr;
      beats_nxt    = beats_left;
      owner_nxt    = owner;
      prio_nxt     = prio;
      gnt0_c       = 1'b0;
      gnt1_c       = 1'b0;
      case (state)
         IDLE: begin
            // prio=0 favours requester 0 when both ask
            if (req0 && (!req1 || !prio)) begin
               gnt0_c = 1'b1;
            end else if (req1) begin
               gnt1_c = 1'b1;
            end
            if (gnt0_c || gnt1_c) begin
               owner_nxt    = gnt1_c;
               cur_addr_nxt = gnt1_c ? addr1 : addr0;
               beats_nxt    = gnt1_c ? len1 : len0;
               rom_addr_nxt = cur_addr_nxt;
               prio_nxt     = !gnt1_c;
               state_nxt    = BURST;
            end
         end
         BURST: begin
            cur_addr_nxt = cur_addr + 4'd1;
            if (beats_left == 2'd0) begin
               state_nxt = DRAIN;
            end else begin
               beats_nxt    = beats_left - 2'd1;
               rom_addr_nxt = cur_addr + 4'd1;
            end
         end
         DRAIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // state sits at IDLE during reset, so gate grants to keep them low there too
   assign gnt0  = gnt0_c && rst_n;
   assign gnt1  = gnt1_c && rst_n;
   assign rdata = rom_data;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
// ROM model returns 16'hA000+address one cycle after the address.
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [3:0]  addr0, addr1;
   logic [1:0]  len0, len1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [15:0] rdata, rom_data;
   logic [3:0]  rom_addr;

   int checks   = 0;
   int failures = 0;
   int rv1n;
   logic [15:0] wrap_exp [0:3];
   logic [8:0]  g0_pat, g1_pat, rv0_pat, rv1_pat;

   rom_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .len0(len0),
      .req1(req1), .addr1(addr1), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= 16'hA000 + {12'h000, rom_addr};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      wrap_exp = '{16'hA00E, 16'hA00F, 16'hA000, 16'hA001};
      g0_pat  = 9'b1_0000_0001;
      g1_pat  = 9'b0_0001_0000;
      rv0_pat = 9'b0_0000_1100;
      rv1_pat = 9'b0_1100_0000;

      // reset with a live request
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0;
      addr0 = 4'd0; addr1 = 4'd0; len0 = 2'd0; len1 = 2'd0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      nc(); rst_n = 1'b1; req0 = 1'b0; #2;
      chk("idle_busy", busy, 0);

      // single-word read
      nc(); req0 = 1'b1; addr0 = 4'd3; len0 = 2'd0; #2;
      chk("s1_gnt0", gnt0, 1);
      chk("s1_gnt1", gnt1, 0);
      nc(); req0 = 1'b0; #2;
      chk("s1_busy_t1", busy, 1);
      chk("s1_rom_addr", rom_addr, 3);
      chk("s1_rvalid0_t1", rvalid0, 0);
      nc(); #2;
      chk("s1_rvalid0_t2", rvalid0, 1);
      chk("s1_rdata", rdata, 16'hA003);
      chk("s1_rvalid1_t2", rvalid1, 0);
      nc(); #2;
      chk("s1_rvalid0_t3", rvalid0, 0);
      nc(); #2;
      chk("s1_busy_t4", busy, 0);
      chk("s1_rom_addr_hold", rom_addr, 3);

      // 4-word burst wrapping past address 15
      nc(); req1 = 1'b1; addr1 = 4'd14; len1 = 2'd3; #2;
      chk("s2_gnt1", gnt1, 1);
      chk("s2_gnt0", gnt0, 0);
      nc(); req1 = 1'b0; #2;
      chk("s2_rom_addr", rom_addr, 14);
      for (int i = 0; i < 4; i++) begin
         nc(); #2;
         chk("s2_rvalid1", rvalid1, 1);
         chk("s2_rdata", rdata, wrap_exp[i]);
         chk("s2_rvalid0", rvalid0, 0);
      end
      nc(); #2;
      chk("s2_rvalid1_end", rvalid1, 0);
      chk("s2_busy_end", busy, 0);

      // both requesting from reset: alternation
      nc(); rst_n = 1'b0; #2;
      nc(); rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; addr0 = 4'd0; addr1 = 4'd8; len0 = 2'd1; len1 = 2'd1;
      #2;
      for (int c = 0; c < 9; c++) begin
         if (c != 0) begin
            nc(); #2;
         end
         chk("s3_gnt0", gnt0, g0_pat[c]);
         chk("s3_gnt1", gnt1, g1_pat[c]);
         chk("s3_rvalid0", rvalid0, rv0_pat[c]);
         chk("s3_rvalid1", rvalid1, rv1_pat[c]);
      end
      nc(); req0 = 1'b0; req1 = 1'b0; #2;
      repeat (3) begin
         nc(); #2;
      end
      chk("s3_busy_idle", busy, 0);

      // req1 arrives mid-burst of requester 0
      nc(); req0 = 1'b1; addr0 = 4'd2; len0 = 2'd3; #2;
      chk("s4_gnt0", gnt0, 1);
      nc(); req0 = 1'b0; req1 = 1'b1; addr1 = 4'd5; len1 = 2'd0; #2;
      chk("s4_gnt1_t1", gnt1, 0);
      for (int k = 2; k <= 5; k++) begin
         nc(); #2;
         chk("s4_gnt1_wait", gnt1, 0);
         chk("s4_rvalid0", rvalid0, 1);
         chk("s4_rvalid1_excl", rvalid1, 0);
      end
      nc(); #2;
      chk("s4_gnt1_t6", gnt1, 1);
      chk("s4_rvalid0_t6", rvalid0, 0);
      nc(); req1 = 1'b0; #2;
      chk("s4_rom_addr", rom_addr, 5);
      nc(); #2;
      chk("s4_rvalid1", rvalid1, 1);
      chk("s4_rdata", rdata, 16'hA005);
      chk("s4_rvalid0_t8", rvalid0, 0);

      // reset during the second beat of a 4-word burst
      nc(); req0 = 1'b1; addr0 = 4'd4; len0 = 2'd3; #2;
      chk("s5_gnt0", gnt0, 1);
      nc(); req0 = 1'b0; #2;
      chk("s5_rom_addr_t1", rom_addr, 4);
      nc(); #2;
      chk("s5_rvalid0_t2", rvalid0, 1);
      chk("s5_rdata_t2", rdata, 16'hA004);
      chk("s5_rom_addr_t2", rom_addr, 5);
      rst_n = 1'b0; #1;
      chk("s5_rvalid0_rst", rvalid0, 0);
      chk("s5_busy_rst", busy, 0);
      chk("s5_rom_addr_rst", rom_addr, 0);
      nc(); #2;
      nc(); rst_n = 1'b1; #2;
      chk("s5_busy_rel", busy, 0);
      repeat (3) begin
         nc(); #2;
         chk("s5_rvalid0_after", rvalid0, 0);
         chk("s5_busy_after", busy, 0);
      end
      nc(); req0 = 1'b1; addr0 = 4'd9; len0 = 2'd0; #2;
      chk("s5_regrant", gnt0, 1);
      nc(); req0 = 1'b0; #2;
      nc(); #2;
      chk("s5_rvalid0_new", rvalid0, 1);
      chk("s5_rdata_new", rdata, 16'hA009);
      nc(); #2;

      // short req0 pulse while requester 1 owns the bus
      nc(); req1 = 1'b1; addr1 = 4'd1; len1 = 2'd2; #2;
      chk("s6_gnt1", gnt1, 1);
      rv1n = 0;
      for (int k = 1; k <= 7; k++) begin
         nc();
         if (k == 1) req1 = 1'b0;
         if (k == 2) req0 = 1'b1;
         if (k == 3) req0 = 1'b0;
         #2;
         chk("s6_no_gnt0", gnt0, 0);
         chk("s6_no_rvalid0", rvalid0, 0);
         if (rvalid1) rv1n++;
      end
      chk("s6_rvalid1_count", rv1n, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
